mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM that sequences the shared MIPS datapath (PC, instruction memory, register file, ALU control, ALU).
//  One instruction at a time: FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK.

---
 rtl/mips_multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle control FSM for the shared MIPS datapath. Only one instruction
//   is in flight at a time: FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK.
//   Control outputs are Moore-decoded from the state register. The exceptions
//   are IRWrite/PCWrite in FETCH, which follow mem_ready, and PCWrite in BEQ,
//   which follows Zero.
//
// Parameters
//   CNT_W : width of the retired-instruction counter
//   ST_W  : width of the exported state code
//
// Ports
//   CLK, RESET       clock, synchronous active-high reset
//   opcode, Zero     instruction opcode and ALU zero flag
//   mem_ready        memory completes the pending access this cycle
//   PCWrite .. PCSource  datapath enables and mux selects
//   state            current state code (debug)
//   instr_count      retired-instruction counter
//   trap             sticky illegal-opcode flag
//
// Build option
//   MCC_TRAP_EN : an unknown opcode parks the FSM in TRAP until RESET.
//                 When undefined, an unknown opcode retires as a NOP.
module mips_multicycle_ctrl #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ST_W  = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [5:0]       opcode,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             PCSource,
   output logic [ST_W-1:0]  state,
   output logic [CNT_W-1:0] instr_count,
   output logic             trap
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_RTEX   = 4'd6;
   localparam logic [3:0] S_RTWB   = 4'd7;
   localparam logic [3:0] S_BEQ    = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_TRAP   = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   // Destination for an opcode DECODE does not recognise
`ifdef MCC_TRAP_EN
   localparam logic [3:0] S_ILLEGAL = S_TRAP;
`else
   localparam logic [3:0] S_ILLEGAL = S_FETCH;
`endif

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       retire_c;

   // State register and retired-instruction counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_FETCH;
         instr_count <= '0;
      end else begin
         state_q <= state_d;
         if (retire_c) instr_count <= instr_count + CNT_W'(1);
      end
   end

   // Next-state and control decode
   always_comb begin
      state_d  = state_q;
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'd0;
      ALUOp    = 2'd0;
      PCSource = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'd3;
            case (opcode)
               OP_RTYPE:     state_d = S_RTEX;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_RTEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_RTWB;
         end
         S_RTWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            PCSource = 1'b1;
            PCWrite  = Zero;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // An instruction retires whenever the FSM returns to FETCH from elsewhere.
   // TRAP never returns to FETCH except through RESET, so it is excluded.
   assign retire_c = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP);

   assign state = ST_W'(state_q);

`ifdef MCC_TRAP_EN
   // Sticky flag, set on entry to TRAP
   always_ff @(posedge CLK) begin
      if (RESET)                 trap <= 1'b0;
      else if (state_d == S_TRAP) trap <= 1'b1;
   end
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Each cycle, expected outputs are derived
// from the intended state and pushed to a scoreboard. The observed outputs
// are popped and compared mid-cycle on the falling edge.
module tb_mips_multicycle_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [5:0]  opcode;
   logic        Zero;
   logic        mem_ready;
   logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
   logic        ALUSrcA, PCSource, trap;
   logic [1:0]  ALUSrcB, ALUOp;
   logic [3:0]  state;
   logic [31:0] instr_count;

   mips_multicycle_ctrl #(.CNT_W(32), .ST_W(4)) dut (
      .CLK(CLK), .RESET(RESET), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .state(state), .instr_count(instr_count), .trap(trap)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0]  st;
      logic        pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
      logic [1:0]  srcb, aluop;
      logic        pcsrc;
      logic [31:0] cnt;
      logic        trap;
   } obs_t;

   obs_t        sb[$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] exp_cnt  = '0;
   logic        exp_trap = 1'b0;

   // Expected control outputs for a given state, built from the control table
   function automatic obs_t expect_for(input logic [3:0] s, input logic z, input logic mr);
      obs_t e = '0;
      e.st   = s;
      e.cnt  = exp_cnt;
      e.trap = exp_trap;
      case (s)
         4'd0:  begin e.mrd = 1'b1; e.srcb = 2'd1; e.irw = mr; e.pcw = mr; end
         4'd1:  e.srcb = 2'd3;
         4'd2:  begin e.srca = 1'b1; e.srcb = 2'd2; end
         4'd3:  begin e.iord = 1'b1; e.mrd = 1'b1; end
         4'd4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
         4'd5:  begin e.iord = 1'b1; e.mwr = 1'b1; end
         4'd6:  begin e.srca = 1'b1; e.aluop = 2'b10; end
         4'd7:  begin e.rdst = 1'b1; e.rw = 1'b1; end
         4'd8:  begin e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 1'b1; e.pcw = z; end
         4'd9:  begin e.srca = 1'b1; e.srcb = 2'd2; end
         4'd10: e.rw = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.st = state; o.pcw = PCWrite; o.iord = IorD; o.mrd = MemRead; o.mwr = MemWrite;
      o.irw = IRWrite; o.m2r = MemtoReg; o.rdst = RegDst; o.rw = RegWrite; o.srca = ALUSrcA;
      o.srcb = ALUSrcB; o.aluop = ALUOp; o.pcsrc = PCSource; o.cnt = instr_count; o.trap = trap;
      return o;
   endfunction

   // Apply inputs for the coming cycle and record what the DUT should show
   task automatic drive(input logic [3:0] s, input logic [5:0] op, input logic z, input logic mr);
      opcode = op; Zero = z; mem_ready = mr;
      sb.push_back(expect_for(s, z, mr));
   endtask

   task automatic test_reset();
      obs_t got, want;
      RESET = 1'b1; opcode = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      drive(4'd0, 6'd0, 1'b0, 1'b1);
      @(negedge CLK);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL reset_fetch got=%h want=%h", got, want); else passed++;
      #1 drive(4'd0, 6'd0, 1'b0, 1'b0);
      #1 got = observe(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL reset_fetch_stall got=%h want=%h", got, want); else passed++;
      @(posedge CLK); #1;
   endtask

   task automatic test_sw_reset();
      obs_t got, want;
      logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      for (int i = 0; i < 4; i++) begin
         RESET = (i == 3);
         drive(seq[i], 6'd43, 1'b0, 1'b1);
         @(negedge CLK);
         got = observe(); want = sb.pop_front(); total++;
         if (got !== want) $display("FAIL sw_reset[%0d] got=%h want=%h", i, got, want); else passed++;
         @(posedge CLK); #1;
      end
      RESET = 1'b0;
      drive(4'd0, 6'd43, 1'b0, 1'b0);
      @(negedge CLK);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL sw_reset_after got=%h want=%h", got, want); else passed++;
      @(posedge CLK); #1;
   endtask

   task automatic test_rtype();
      obs_t got, want;
      logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
      for (int i = 0; i < 4; i++) begin
         drive(seq[i], 6'd0, 1'b0, 1'b1);
         @(negedge CLK);
         got = observe(); want = sb.pop_front(); total++;
         if (got !== want) $display("FAIL rtype[%0d] got=%h want=%h", i, got, want); else passed++;
         @(posedge CLK); #1;
      end
      exp_cnt++;
      total++;
      if (state !== 4'd0 || instr_count !== exp_cnt)
         $display("FAIL rtype_retire state=%0d count=%0d want state=0 count=%0d", state, instr_count, exp_cnt);
      else passed++;
   endtask

   task automatic test_lw_stall();
      obs_t got, want;
      logic [3:0] seq [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
      logic       mr  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         drive(seq[i], 6'd35, 1'b0, mr[i]);
         @(negedge CLK);
         got = observe(); want = sb.pop_front(); total++;
         if (got !== want) $display("FAIL lw_stall[%0d] got=%h want=%h", i, got, want); else passed++;
         @(posedge CLK); #1;
      end
      exp_cnt++;
   endtask

   task automatic test_beq();
      obs_t got, want;
      logic [3:0] seq [3] = '{4'd0, 4'd1, 4'd8};
      for (int z = 1; z >= 0; z--) begin
         for (int i = 0; i < 3; i++) begin
            drive(seq[i], 6'd4, 1'(z), 1'b1);
            @(negedge CLK);
            got = observe(); want = sb.pop_front(); total++;
            if (got !== want) $display("FAIL beq_z%0d[%0d] got=%h want=%h", z, i, got, want); else passed++;
            @(posedge CLK); #1;
         end
         exp_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, want;
      logic [3:0] seq [5] = '{4'd0, 4'd0, 4'd1, 4'd9, 4'd10};
      logic       mr  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         drive(seq[i], 6'd8, 1'b1, mr[i]);
         @(negedge CLK);
         got = observe(); want = sb.pop_front(); total++;
         if (got !== want) $display("FAIL addi[%0d] got=%h want=%h", i, got, want); else passed++;
         @(posedge CLK); #1;
      end
      exp_cnt++;
      test_rtype();
   endtask

   task automatic test_illegal();
      obs_t got, want;
      logic [3:0] seq [2] = '{4'd0, 4'd1};
      for (int i = 0; i < 2; i++) begin
         drive(seq[i], 6'd63, 1'b0, 1'b1);
         @(negedge CLK);
         got = observe(); want = sb.pop_front(); total++;
         if (got !== want) $display("FAIL illegal[%0d] got=%h want=%h", i, got, want); else passed++;
         @(posedge CLK); #1;
      end
`ifdef MCC_TRAP_EN
      exp_trap = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(4'd11, 6'd63, 1'b1, 1'b1);
         @(negedge CLK);
         got = observe(); want = sb.pop_front(); total++;
         if (got !== want) $display("FAIL trap_hold[%0d] got=%h want=%h", i, got, want); else passed++;
         @(posedge CLK); #1;
      end
`else
      exp_cnt++;
      drive(4'd0, 6'd0, 1'b0, 1'b0);
      @(negedge CLK);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL illegal_nop got=%h want=%h", got, want); else passed++;
      @(posedge CLK); #1;
`endif
   endtask

   initial begin
      test_reset();
      test_sw_reset();
      test_rtype();
      test_lw_stall();
      test_beq();
      test_back_to_back();
      test_illegal();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
